// File: rtl/controller_port.sv
// -----------------------------------------------------------------------------
// controller_port
//   CPU-facing $4016/$4017 responder. Polls two NES pads over the 4021
//   latch/clock/data serial protocol, keeps an atomic 8-button snapshot per
//   pad, and presents the classic strobe/serial-shift register model to the
//   CPU. Button order (bit 0..7): A, B, Select, Start, Up, Down, Left, Right.
// -----------------------------------------------------------------------------
module controller_port #(
  parameter int CLK_DIV  = 300,     // system clocks per PAD_LATCH/PAD_CLK phase
  parameter int POLL_DIV = 833333   // idle clocks between the end of one poll and the next
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CPU_CE,
  input  logic       CPU_WR,        // 1 = read, 0 = write
  input  logic [7:0] CPU_DO,
  input  logic       CONTROL1_EN,
  input  logic       CONTROL2_EN,
  output logic [7:0] CONTROL1,
  output logic [7:0] CONTROL2,
  output logic       PAD_LATCH,
  output logic       PAD_CLK,
  input  logic       PAD1_DATA,
  input  logic       PAD2_DATA,
  output logic [7:0] BTN1,
  output logic [7:0] BTN2,
  output logic       POLL_DONE
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam int DIV_W = $clog2(2 * CLK_DIV + 1);
  localparam int TMR_W = $clog2(POLL_DIV + 1);

  localparam logic [DIV_W-1:0] LATCH_LAST  = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] PHASE_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] POLL_RELOAD = TMR_W'(POLL_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LATCH = 3'd1;
  localparam logic [2:0] S_LOW   = 3'd2;
  localparam logic [2:0] S_HIGH  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Upper read-data bits are open bus on the real console; the usual value
  // returned is $40.
  localparam logic [6:0] OPEN_BUS_HI = 7'b0100000;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  logic [1:0]       pad1_sync;
  logic [1:0]       pad2_sync;
  logic             pad1_pressed;
  logic             pad2_pressed;

  logic [2:0]       state;
  logic [2:0]       next_state;
  logic [DIV_W-1:0] div_cnt;
  logic [TMR_W-1:0] timer;
  logic [2:0]       bit_cnt;
  logic [7:0]       shadow1;
  logic [7:0]       shadow2;
  logic             sample_now;

  logic [7:0]       btn1_q;
  logic [7:0]       btn2_q;
  logic             poll_done_q;
  logic             pad_latch_q;
  logic             pad_clk_q;

  logic             strobe;
  logic [7:0]       sr1;
  logic [7:0]       sr2;
  logic             wr_4016;
  logic             rd_4016;
  logic             rd_4017;

  // Only bit 0 of a $4016 write carries meaning (the strobe).
  logic             unused_cpu_do;
  assign unused_cpu_do = ^CPU_DO[7:1];

  // ---------------------------------------------------------------------------
  // Pad data synchronizers: pads are clocked from our own PAD_CLK but the
  // returned data still crosses cable delay and is treated as asynchronous.
  // Idle level is 1 (nothing pressed).
  // ---------------------------------------------------------------------------
  // Two-flop synchronizers for both pad data lines.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pad1_sync <= 2'b11;
      pad2_sync <= 2'b11;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value; blocking here would collapse the
      // synchronizer to a single stage.
      pad1_sync <= {pad1_sync[0], PAD1_DATA};
      pad2_sync <= {pad2_sync[0], PAD2_DATA};
    end
  end

  // Pad data is active-low; convert to pressed=1.
  assign pad1_pressed = ~pad1_sync[1];
  assign pad2_pressed = ~pad2_sync[1];

  // ---------------------------------------------------------------------------
  // Poll FSM
  // ---------------------------------------------------------------------------
  // Next-state decode for the poll sequencer.
  always_comb begin
    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    next_state = state;
    case (state)
      S_IDLE:  if (timer == '0)          next_state = S_LATCH;
      S_LATCH: if (div_cnt == LATCH_LAST) next_state = S_LOW;
      S_LOW:   if (div_cnt == PHASE_LAST) next_state = (bit_cnt == 3'd7) ? S_DONE : S_HIGH;
      S_HIGH:  if (div_cnt == PHASE_LAST) next_state = S_LOW;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Data is sampled on the last cycle of each low phase, i.e. just before
  // the PAD_CLK rising edge that shifts the next bit out of the 4021.
  assign sample_now = (state == S_LOW) && (div_cnt == PHASE_LAST);

  // Sequencer state, phase counter, bit index and idle timer.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= S_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      timer   <= '0;     // first poll starts right after reset release
    end else begin
      state <= next_state;

      if (next_state != state) begin
        div_cnt <= '0;
      end else if (state != S_IDLE) begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (state == S_IDLE && next_state == S_LATCH) begin
        bit_cnt <= '0;
      end else if (state == S_HIGH && next_state == S_LOW) begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (state == S_DONE) begin
        timer <= POLL_RELOAD;
      end else if (state == S_IDLE && timer != '0) begin
        timer <= timer - 1'b1;
      end
    end
  end

  // Pad strobe/clock outputs registered from the next state so they are
  // glitch-free and line up exactly with the state they represent.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pad_latch_q <= 1'b0;
      pad_clk_q   <= 1'b0;
    end else begin
      pad_latch_q <= (next_state == S_LATCH);
      pad_clk_q   <= (next_state == S_HIGH);
    end
  end

  // Shadow capture during the poll; snapshot commit once all 8 bits are in.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      // NOTE: the shadows are plain registers, so resetting them is cheap and
      // guarantees an abandoned poll leaves nothing behind; only true RAM
      // arrays would be left without reset.
      shadow1     <= '0;
      shadow2     <= '0;
      btn1_q      <= '0;
      btn2_q      <= '0;
      poll_done_q <= 1'b0;
    end else begin
      if (sample_now) begin
        shadow1[bit_cnt] <= pad1_pressed;
        shadow2[bit_cnt] <= pad2_pressed;
      end

      // Both pads commit together so software never sees a torn pair.
      poll_done_q <= (state == S_DONE);
      if (state == S_DONE) begin
        btn1_q <= shadow1;
        btn2_q <= shadow2;
      end
    end
  end

  assign PAD_LATCH = pad_latch_q;
  assign PAD_CLK   = pad_clk_q;
  assign BTN1      = btn1_q;
  assign BTN2      = btn2_q;
  assign POLL_DONE = poll_done_q;

  // ---------------------------------------------------------------------------
  // CPU side: strobe and serial shift registers
  // ---------------------------------------------------------------------------
  // $4017 writes belong to the APU frame counter and are deliberately ignored.
  assign wr_4016 = CPU_CE & CONTROL1_EN & ~CPU_WR;
  assign rd_4016 = CPU_CE & CONTROL1_EN &  CPU_WR;
  assign rd_4017 = CPU_CE & CONTROL2_EN &  CPU_WR;

  // Strobe latch written through $4016 bit 0.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      strobe <= 1'b0;
    end else if (wr_4016) begin
      strobe <= CPU_DO[0];
    end
  end

  // Shift registers: reload continuously while strobed, otherwise shift one
  // bit per read, filling with 1 so reads past the eighth return 1.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sr1 <= '0;
      sr2 <= '0;
    end else if (strobe) begin
      sr1 <= btn1_q;
      sr2 <= btn2_q;
    end else begin
      if (rd_4016) sr1 <= {1'b1, sr1[7:1]};
      if (rd_4017) sr2 <= {1'b1, sr2[7:1]};
    end
  end

  // Read data is the pre-shift bit, combinational from the registers.
  assign CONTROL1 = {OPEN_BUS_HI, sr1[0]};
  assign CONTROL2 = {OPEN_BUS_HI, sr2[0]};

endmodule

// File: doc/controller_port.md
Name: controller_port

Overview:
- CPU-facing responder behind the $4016/$4017 decode.
- Polls two physical NES pads over the 4021 latch/clock/data serial protocol and holds an atomic 8-button snapshot per pad.
- Presents the standard strobe/serial-shift register model to the CPU through CONTROL1/CONTROL2 (read data) and CONTROL1_EN/CONTROL2_EN (address decodes).

Parameters:
CLK_DIV, 300, system clocks per PAD_LATCH/PAD_CLK phase (half period); must be >= 1
POLL_DIV, 833333, system clocks from end of one pad poll to start of the next; must be >= 1

Ports:
CLK  input  1  system clock
RESET_N  input  1  asynchronous, active-low reset
CPU_CE  input  1  one-cycle pulse marking the CPU bus cycle in which the access takes effect
CPU_WR  input  1  CPU read/write: 1 = read, 0 = write
CPU_DO  input  8  CPU write data
CONTROL1_EN  input  1  address decode for $4016
CONTROL2_EN  input  1  address decode for $4017
CONTROL1  output  8  $4016 read data
CONTROL2  output  8  $4017 read data
PAD_LATCH  output  1  latch pulse to both pads
PAD_CLK  output  1  shift clock to both pads
PAD1_DATA  input  1  pad 1 serial data, active-low (0 = pressed), asynchronous to CLK
PAD2_DATA  input  1  pad 2 serial data, active-low, asynchronous to CLK
BTN1  output  8  pad 1 snapshot, 1 = pressed
BTN2  output  8  pad 2 snapshot, 1 = pressed
POLL_DONE  output  1  one-cycle pulse when the snapshots update

Behaviour:
- Reset values:
  - PAD_LATCH=0, PAD_CLK=0, BTN1=BTN2=8'h00, POLL_DONE=0.
  - Strobe=0, shift registers SR1=SR2=8'h00, so CONTROL1=CONTROL2=8'h40.
  - Poll FSM enters S_IDLE with poll timer=0, so the first poll starts on the first cycle after reset release.
  - Reset asserted mid-poll abandons the poll; the partial snapshot is discarded.
- Button bit order: 0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
- PAD1_DATA and PAD2_DATA each pass through a 2-flop synchronizer; the sampled value is inverted to give pressed=1.
- Poll FSM states:
  - S_IDLE: decrement timer; at 0 go to S_LATCH, bit_cnt=0.
  - S_LATCH: PAD_LATCH=1 for 2*CLK_DIV cycles, then go to S_LOW.
  - S_LOW: PAD_LATCH=0, PAD_CLK=0 for CLK_DIV cycles. On the last cycle, capture synchronized data into shadow[bit_cnt] for both pads. If bit_cnt==7 go to S_DONE, else go to S_HIGH.
  - S_HIGH: PAD_CLK=1 for CLK_DIV cycles, then bit_cnt++ and go to S_LOW.
  - S_DONE: one cycle. BTN1/BTN2 <= shadows (both pads together), POLL_DONE=1, timer=POLL_DIV-1, go to S_IDLE.
  - A poll produces exactly 7 PAD_CLK rising edges.
- CPU strobe:
  - Write access is CPU_CE & CONTROL1_EN & ~CPU_WR; on it, strobe <= CPU_DO[0].
  - Writes with CONTROL2_EN ($4017, the APU frame counter) are ignored.
- Shift registers (applied to SR1 and SR2 independently):
  - Strobe=1: SR <= BTNx every cycle, including a snapshot committed while strobe is high (visible the next cycle).
  - Strobe=0: SR holds; a new snapshot is not visible until the next strobe.
  - Read access (CPU_CE & CONTROLx_EN & CPU_WR) with strobe=0: SR <= {1'b1, SR[7:1]} at the end of that cycle.
  - Read with strobe=1: no shift; returns the current A bit.
  - After 8 reads, all further reads return 1 until re-strobed.
  - A read of $4016 shifts only SR1; a read of $4017 shifts only SR2.
- Read data:
  - CONTROL1 = {7'b0100000, SR1[0]}; CONTROL2 = {7'b0100000, SR2[0]}.
  - Both are combinational from the registers, valid regardless of CPU_CE.
  - The value read in an access is the pre-shift bit.
- EN high with CPU_CE low: no state change.
- A read and a write cannot coincide within one CE; a write takes effect at the end of its cycle.

Test Plan:
(Tests run with CLK_DIV=2, POLL_DIV=16.)
- Pad 1 drives serial data for pressed A, Start, Right (PAD1_DATA low on bits 0, 3, 7) -> exactly 7 PAD_CLK rising edges; PAD_LATCH high for 4 cycles; POLL_DONE pulse; BTN1=8'h89; BTN2=8'h00 with PAD2_DATA held high.
- BTN1=8'h89; write $4016=1 then $4016=0; 10 reads of $4016 -> CONTROL1 LSB sequence 1,0,0,1,0,0,0,1,1,1 with upper bits 7'b0100000.
- Strobe held at 1; 3 reads of $4016 -> every read returns 8'h41 (A pressed) with no shift. A snapshot changing A to released while strobe=1 -> the next read returns 8'h40.
- Strobe cleared; 2 reads of $4017 with BTN2=8'h03 -> CONTROL2 returns 8'h41, 8'h41; a following $4016 read returns BTN1 bit0, unshifted. Write $4017=8'h01 -> strobe unchanged.
- Reset asserted during S_HIGH of bit 4 -> PAD_CLK=0, PAD_LATCH=0, BTN1/BTN2=0, CONTROL1=8'h40 immediately. After release, a new full poll starts with S_LATCH.
- Snapshot committed while strobe=0, mid-read sequence -> remaining reads continue from the old shift contents.
